// File: rtl/porta_rolante_planta_if.sv
// Motor command / sensor bundle between the door controller and the plant.
// PORTA_PLANTA_SENSOR_FAULT_EN adds the inject_fault line.
interface porta_rolante_planta_if #(
  parameter int POS_BITS = 4
);
  logic                motor_abrindo;
  logic                motor_fechando;
  logic                clear_falha;
  logic                em_baixo;
  logic                no_meio;
  logic                em_cima;
  logic [POS_BITS-1:0] pos;
  logic                movendo;
  logic                falha;
`ifdef PORTA_PLANTA_SENSOR_FAULT_EN
  logic                inject_fault;

  modport master (
    output motor_abrindo, motor_fechando,
    output clear_falha, inject_fault,
    input  em_baixo, no_meio, em_cima,
    input  pos, movendo, falha
  );
  modport slave (
    input  motor_abrindo, motor_fechando,
    input  clear_falha, inject_fault,
    output em_baixo, no_meio, em_cima,
    output pos, movendo, falha
  );
`else
  modport master (
    output motor_abrindo, motor_fechando,
    output clear_falha,
    input  em_baixo, no_meio, em_cima,
    input  pos, movendo, falha
  );
  modport slave (
    input  motor_abrindo, motor_fechando,
    input  clear_falha,
    output em_baixo, no_meio, em_cima,
    output pos, movendo, falha
  );
`endif
endinterface

// File: rtl/porta_rolante_planta.sv
// Rolling door plant: integrates position from motor drive, flags faults.
// PORTA_PLANTA_SENSOR_FAULT_EN enables illegal sensor injection.
module porta_rolante_planta #(
  parameter int TRAVEL_TICKS = 8,
  parameter int POS_BITS     = 4,
  parameter int STEP_DIV     = 2,
  parameter int STALL_LIMIT  = 4,
  parameter int INIT_POS     = 0
) (
  input logic                   clk_2,
  input logic                   reset_n,
  porta_rolante_planta_if.slave bus
);
  typedef enum logic [1:0] {
    PARADO, SUBINDO, DESCENDO, FALHA
  } state_t;

  localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(STEP_DIV - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT - 1);
  localparam logic [POS_BITS-1:0] TOP = POS_BITS'(TRAVEL_TICKS);
  localparam logic [POS_BITS-1:0] INIT = POS_BITS'(INIT_POS);

  state_t              state;
  state_t              want;
  logic [POS_BITS-1:0] pos;
  logic [DW-1:0]       div_cnt;
  logic [SW-1:0]       stall_cnt;
  logic                falha;
  logic                movendo;
  logic                both;
  logic                at_stop;

  assign both = bus.motor_abrindo & bus.motor_fechando;

  always_comb begin
    want = PARADO;
    unique case (1'b1)
      bus.motor_abrindo && !bus.motor_fechando:
        want = SUBINDO;
      bus.motor_fechando && !bus.motor_abrindo:
        want = DESCENDO;
      default:
        want = PARADO;
    endcase
  end

  assign at_stop =
    (state == SUBINDO && pos == TOP) ||
    (state == DESCENDO && pos == '0);

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PARADO;
      pos       <= INIT;
      div_cnt   <= '0;
      stall_cnt <= '0;
      falha     <= 1'b0;
      movendo   <= 1'b0;
    end else if (both) begin
      state     <= FALHA;
      falha     <= 1'b1;
      movendo   <= 1'b0;
      div_cnt   <= '0;
      stall_cnt <= '0;
    end else if (state == FALHA) begin
      div_cnt   <= '0;
      stall_cnt <= '0;
      if (bus.clear_falha) begin
        state <= PARADO;
        falha <= 1'b0;
      end
    end else begin
      state     <= want;
      movendo   <= (want != PARADO);
      div_cnt   <= '0;
      stall_cnt <= '0;
      // Only an uninterrupted drive in one direction accumulates.
      if (want == state && state != PARADO) begin
        if (at_stop) begin
          if (stall_cnt == STALL_MAX) begin
            state   <= FALHA;
            falha   <= 1'b1;
            movendo <= 1'b0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end else if (div_cnt == DIV_MAX) begin
          pos <= (state == SUBINDO) ? pos + 1'b1
                                    : pos - 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.em_baixo = (pos == '0);
    bus.em_cima  = (pos == TOP);
    bus.no_meio  = (pos != '0) && (pos != TOP);
`ifdef PORTA_PLANTA_SENSOR_FAULT_EN
    if (bus.inject_fault) begin
      bus.em_baixo = 1'b1;
      bus.em_cima  = 1'b1;
      bus.no_meio  = 1'b0;
    end
`endif
  end

  assign bus.pos     = pos;
  assign bus.falha   = falha;
  assign bus.movendo = movendo;
endmodule

// File: tb/tb_porta_rolante_planta.sv
// Closed-loop bench for porta_rolante_planta: directed motor sequences,
// a travel-level reference model, and literal checkpoints.
module tb_porta_rolante_planta;
  localparam int TRAVEL = 8;
  localparam int PB     = 4;
  localparam int DIV    = 2;
  localparam int STALL  = 4;
  localparam int INIT   = 0;

  logic clk_2;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  porta_rolante_planta_if #(.POS_BITS(PB)) bus ();

  porta_rolante_planta #(
    .TRAVEL_TICKS(TRAVEL),
    .POS_BITS(PB),
    .STEP_DIV(DIV),
    .STALL_LIMIT(STALL),
    .INIT_POS(INIT)
  ) dut (
    .clk_2(clk_2),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Model: door position, drive direction (+1/-1/0, 2 = faulted),
  // and how long the current drive has lasted since the last move.
  int m_pos;
  int m_dir;
  int m_held;
  bit m_flt;
  int want;

  always @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      m_pos  = INIT;
      m_dir  = 0;
      m_held = 0;
      m_flt  = 0;
    end else if (bus.motor_abrindo && bus.motor_fechando) begin
      m_dir  = 2;
      m_flt  = 1;
      m_held = 0;
    end else if (m_dir == 2) begin
      if (bus.clear_falha) begin
        m_dir = 0;
        m_flt = 0;
      end
    end else begin
      want = bus.motor_abrindo ? 1 : (bus.motor_fechando ? -1 : 0);
      if (want != m_dir || want == 0) begin
        m_dir  = want;
        m_held = 0;
      end else begin
        m_held++;
        if (m_pos + m_dir < 0 || m_pos + m_dir > TRAVEL) begin
          if (m_held == STALL) begin
            m_dir  = 2;
            m_flt  = 1;
            m_held = 0;
          end
        end else if (m_held == DIV) begin
          m_pos  = m_pos + m_dir;
          m_held = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp,
               $time);
    end
  endtask

  bit inj;

  always @(negedge clk_2) begin
`ifdef PORTA_PLANTA_SENSOR_FAULT_EN
    inj = bus.inject_fault;
`else
    inj = 0;
`endif
    chk("model_pos", int'(bus.pos), m_pos);
    chk("model_falha", int'(bus.falha), int'(m_flt));
    chk("model_movendo", int'(bus.movendo),
        int'(m_dir == 1 || m_dir == -1));
    chk("model_em_baixo", int'(bus.em_baixo),
        int'(inj || m_pos == 0));
    chk("model_em_cima", int'(bus.em_cima),
        int'(inj || m_pos == TRAVEL));
    chk("model_no_meio", int'(bus.no_meio),
        int'(!inj && m_pos > 0 && m_pos < TRAVEL));
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk_2);
    #1;
  endtask

  task automatic drive(input bit a, input bit f, input bit c);
    bus.motor_abrindo  = a;
    bus.motor_fechando = f;
    bus.clear_falha    = c;
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drive(0, 0, 0);
`ifdef PORTA_PLANTA_SENSOR_FAULT_EN
    bus.inject_fault = 1'b0;
`endif
    edges(2);
    reset_n = 1'b1;
    chk("rst_pos", int'(bus.pos), 0);
    chk("rst_em_baixo", int'(bus.em_baixo), 1);
    chk("rst_no_meio", int'(bus.no_meio), 0);
    chk("rst_em_cima", int'(bus.em_cima), 0);
    chk("rst_falha", int'(bus.falha), 0);
    chk("rst_movendo", int'(bus.movendo), 0);

    // Open from closed
    drive(1, 0, 1);
    edges(3);
    chk("open_pos1", int'(bus.pos), 1);
    chk("open_no_meio", int'(bus.no_meio), 1);
    edges(14);
    chk("open_pos8", int'(bus.pos), 8);
    chk("open_em_cima", int'(bus.em_cima), 1);
    edges(2);
    drive(0, 0, 0);
    edges(1);
    chk("short_stall_falha", int'(bus.falha), 0);
    chk("sat_pos8", int'(bus.pos), 8);

    // Stall against the open stop
    drive(1, 0, 0);
    edges(4);
    chk("stall3_falha", int'(bus.falha), 0);
    edges(1);
    chk("stall4_falha", int'(bus.falha), 1);
    chk("stall_pos", int'(bus.pos), 8);
    drive(0, 0, 1);
    edges(1);
    chk("stall_clear", int'(bus.falha), 0);

    // Close to mid travel, then both motors
    drive(0, 1, 0);
    edges(9);
    chk("close_pos4", int'(bus.pos), 4);
    drive(1, 1, 0);
    edges(1);
    chk("both_falha", int'(bus.falha), 1);
    chk("both_pos", int'(bus.pos), 4);
    drive(1, 1, 1);
    edges(2);
    chk("both_hold_pos", int'(bus.pos), 4);
    chk("both_no_clear", int'(bus.falha), 1);
    drive(0, 0, 0);
    edges(1);
    chk("falha_sticky", int'(bus.falha), 1);
    drive(0, 0, 1);
    edges(1);
    chk("falha_cleared", int'(bus.falha), 0);
    chk("falha_movendo", int'(bus.movendo), 0);

    // Reverse at pos 5
    drive(1, 0, 0);
    edges(3);
    chk("rev_pos5", int'(bus.pos), 5);
    drive(0, 1, 1);
    edges(3);
    chk("rev_pos4", int'(bus.pos), 4);
    chk("rev_falha", int'(bus.falha), 0);

`ifdef PORTA_PLANTA_SENSOR_FAULT_EN
    edges(2);
    chk("inj_pre_pos3", int'(bus.pos), 3);
    drive(0, 0, 0);
    bus.inject_fault = 1'b1;
    #1;
    chk("inj_em_baixo", int'(bus.em_baixo), 1);
    chk("inj_em_cima", int'(bus.em_cima), 1);
    chk("inj_no_meio", int'(bus.no_meio), 0);
    edges(2);
    chk("inj_pos3", int'(bus.pos), 3);
    bus.inject_fault = 1'b0;
    #1;
    chk("inj_release_meio", int'(bus.no_meio), 1);
    drive(0, 1, 0);
    edges(2);
`endif

    // Asynchronous reset mid-travel
    edges(1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pos", int'(bus.pos), 0);
    chk("arst_em_baixo", int'(bus.em_baixo), 1);
    chk("arst_movendo", int'(bus.movendo), 0);
    drive(0, 0, 0);
    edges(1);
    reset_n = 1'b1;
    drive(1, 0, 0);
    edges(3);
    chk("post_rst_pos1", int'(bus.pos), 1);
    drive(0, 0, 0);
    edges(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
